// File: rtl/gh_xcd_word_handshake_if.sv
// Word handshake bundle between a source (iclk) side and a destination (oclk) side.
// Overrun signals exist only when GH_XCD_OVERRUN_EN is defined.
interface gh_xcd_word_handshake_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             i_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_ready;
`ifdef GH_XCD_OVERRUN_EN
    logic             ovr;
    logic             ovr_clr;
`endif

`ifdef GH_XCD_OVERRUN_EN
    modport master (
        output i_valid, i_data, o_ready, ovr_clr,
        input  i_ready, o_valid, o_data, ovr
    );
    modport slave (
        input  i_valid, i_data, o_ready, ovr_clr,
        output i_ready, o_valid, o_data, ovr
    );
`else
    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data
    );
    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data
    );
`endif
endinterface

// File: rtl/gh_xcd_word_handshake.sv
// Single-word iclk -> oclk crossing using a toggle req/ack handshake with a frozen holding register.
// Optional sticky overrun flag (ovr/ovr_clr) when GH_XCD_OVERRUN_EN is defined.
module gh_xcd_word_handshake #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         iclk,
    input  logic                         oclk,
    input  logic                         rst,
    gh_xcd_word_handshake_if.slave       bus
);

    typedef enum logic {SRC_IDLE, SRC_BUSY}  src_state_t;
    typedef enum logic {DST_EMPTY, DST_FULL} dst_state_t;

    // Source domain state
    logic                   req;
    logic [WIDTH-1:0]       hold;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    src_state_t             src_state;
    logic                   accept;

    // Destination domain state
    logic                   ack;
    logic                   seen;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_sync;
    logic [WIDTH-1:0]       o_data_q;
    dst_state_t             dst_state;

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    assign req_sync = req_sync_q[SYNC_STAGES-1];

    // The source is busy exactly while a request toggle has not yet been acknowledged.
    always_comb begin
        src_state = (req == ack_sync) ? SRC_IDLE : SRC_BUSY;
    end

    assign bus.i_ready = (src_state == SRC_IDLE);
    assign accept      = bus.i_valid && (src_state == SRC_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            req        <= 1'b0;
            hold       <= '0;
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
            if (accept) begin
                hold <= bus.i_data;
                req  <= ~req;
            end
        end
    end

    // NOTE: hold crosses unsynchronized; it is frozen from the req toggle until ack returns,
    // and oclk only reads it after req_sync has changed, so it is never caught mid-update.
    always_ff @(posedge oclk or posedge rst) begin
        if (rst) begin
            req_sync_q <= '0;
            seen       <= 1'b0;
            ack        <= 1'b0;
            o_data_q   <= '0;
            dst_state  <= DST_EMPTY;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req};
            case (dst_state)
                DST_EMPTY: begin
                    if (req_sync != seen) begin
                        o_data_q  <= hold;
                        seen      <= req_sync;
                        dst_state <= DST_FULL;
                    end
                end
                DST_FULL: begin
                    if (bus.o_ready) begin
                        ack       <= seen;
                        dst_state <= DST_EMPTY;
                    end
                end
                default: dst_state <= DST_EMPTY;
            endcase
        end
    end

    assign bus.o_valid = (dst_state == DST_FULL);
    assign bus.o_data  = o_data_q;

`ifdef GH_XCD_OVERRUN_EN
    logic ovr_q;

    // A new dropped offer takes priority over a clear in the same cycle.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (bus.i_valid && (src_state == SRC_BUSY)) begin
            ovr_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign bus.ovr = ovr_q;
`endif

endmodule
